mix_columns_iter: RTL

Iterative AES MixColumns / InvMixColumns stage that sits directly upstream of the AddRoundKey stage. It takes the 128-bit state after ShiftRows (or InvShiftRows) and processes one 32-bit column per clock. It then holds the 128-bit result for the AddRoundKey input under a valid/ready handshake. Only GF(2^8) xtime arithmetic is used; there is no S-box and no key material.

---
 rtl/mix_columns_iter_if.sv | 21 ++
 rtl/mix_columns_iter.sv | 99 +++++++++
 2 files changed

// File: rtl/mix_columns_iter_if.sv
// Handshake bundle between the ShiftRows feeder, the iterative MixColumns stage
// and the AddRoundKey input.
interface mix_columns_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic         in_inv;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;

    modport master (
        output in_valid, in_data, in_inv, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_inv, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/mix_columns_iter.sv
// Iterative AES MixColumns / InvMixColumns: one 32-bit column per clock, the
// finished 128-bit state is then held for AddRoundKey under valid/ready.
module mix_columns_iter (
    input  logic              clk,
    input  logic              rst_n,
    mix_columns_iter_if.slave bus,
    output logic              busy
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       fsm_q, fsm_d;
    logic [3:0][31:0] st_q, st_d;    // st_q[3] holds column 0 (MSB word)
    logic [1:0]       col_q, col_d;
    logic             mode_q, mode_d;

    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] mul4(input logic [7:0] x);
        return xtime(xtime(x));
    endfunction

    function automatic logic [7:0] mul8(input logic [7:0] x);
        return xtime(mul4(x));
    endfunction

    // Output byte for row r given the column rotated so that a0 = a_r.
    function automatic logic [7:0] mix_byte(input logic [7:0] a0, input logic [7:0] a1,
                                            input logic [7:0] a2, input logic [7:0] a3,
                                            input logic inv);
        if (!inv)
            return xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        // 0e = 8^4^2, 0b = 8^2^1, 0d = 8^4^1, 09 = 8^1
        return mul8(a0) ^ mul4(a0) ^ xtime(a0)
             ^ mul8(a1) ^ xtime(a1) ^ a1
             ^ mul8(a2) ^ mul4(a2) ^ a2
             ^ mul8(a3) ^ a3;
    endfunction

    function automatic logic [31:0] col_xform(input logic [31:0] c, input logic inv);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {mix_byte(a0, a1, a2, a3, inv), mix_byte(a1, a2, a3, a0, inv),
                mix_byte(a2, a3, a0, a1, inv), mix_byte(a3, a0, a1, a2, inv)};
    endfunction

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no path leaves it unassigned (no latch).
        fsm_d  = fsm_q;
        st_d   = st_q;
        col_d  = col_q;
        mode_d = mode_q;
        case (fsm_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    st_d   = bus.in_data;
                    mode_d = bus.in_inv;
                    col_d  = 2'd0;
                    fsm_d  = S_CALC;
                end
            end
            S_CALC: begin
                st_d[2'd3 - col_q] = col_xform(st_q[2'd3 - col_q], mode_q);
                col_d = col_q + 2'd1;
                if (col_q == 2'd3)
                    fsm_d = S_DONE;
            end
            S_DONE: begin
                if (bus.out_ready)
                    fsm_d = S_IDLE;
            end
            default: fsm_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the state register is reset too, because out_data must read zero straight out of reset.
            fsm_q  <= S_IDLE;
            st_q   <= '0;
            col_q  <= 2'd0;
            mode_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            fsm_q  <= fsm_d;
            st_q   <= st_d;
            col_q  <= col_d;
            mode_q <= mode_d;
        end
    end

    assign bus.in_ready  = (fsm_q == S_IDLE);
    assign bus.out_valid = (fsm_q == S_DONE);
    assign bus.out_data  = st_q;
    assign busy          = (fsm_q != S_IDLE);
endmodule
